// File: rtl/mdu_hilo.sv
// Multiply/divide unit with architectural HI/LO registers for the EX stage.
// Results are computed from the operands captured at start and committed after a fixed latency.
module mdu_hilo #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             w,
    input  logic             w_sel,
    input  logic [WIDTH-1:0] wd,
    input  logic             hl_sel,
    input  logic             flush,
    output logic [WIDTH-1:0] rd,
    output logic             busy
);
    localparam int MAX_N = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAX_N + 1);
    localparam int DW    = 2 * WIDTH;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic [DW-1:0]    result;
    logic             result_ok;

    // Full-width product; sign extension selects signed vs unsigned, low DW bits are exact either way.
    function automatic logic [DW-1:0] mul_full(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic             sgn);
        logic signed [DW-1:0] xe;
        logic signed [DW-1:0] ye;
        logic signed [DW-1:0] pe;
        xe = sgn ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
        ye = sgn ? {{WIDTH{y[WIDTH-1]}}, y} : {{WIDTH{1'b0}}, y};
        pe = xe * ye;
        return pe;
    endfunction

    // Returns {remainder, quotient}. Signed division works on magnitudes, so MIN / -1
    // naturally yields quotient MIN and remainder 0.
    function automatic logic [DW-1:0] div_full(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic             sgn);
        logic [WIDTH-1:0] ux, uy, uq, ur;
        logic             neg_x, neg_y, neg_q;
        neg_x = sgn & x[WIDTH-1];
        neg_y = sgn & y[WIDTH-1];
        neg_q = neg_x ^ neg_y;
        ux    = neg_x ? -x : x;
        uy    = neg_y ? -y : y;
        uq    = (uy == '0) ? '0 : ux / uy;
        ur    = (uy == '0) ? '0 : ux % uy;
        return {(neg_x ? -ur : ur), (neg_q ? -uq : uq)};
    endfunction

    always_comb begin
        result    = '0;
        result_ok = 1'b1;
        case (op_q)
            3'b000, 3'b001: result = mul_full(a_q, b_q, ~op_q[0]);
            3'b010, 3'b011: begin
                result    = div_full(a_q, b_q, ~op_q[0]);
                result_ok = (b_q != '0);
            end
            3'b100, 3'b101: result = acc_q + mul_full(a_q, b_q, ~op_q[0]);
            default:        result = acc_q - mul_full(a_q, b_q, ~op_q[0]);
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    state_d = RUN;
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    acc_d   = {hi_q, lo_q};
                    cnt_d   = (op[2:1] == 2'b01) ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
                end else if (w) begin
                    if (w_sel) hi_d = wd;
                    else       lo_d = wd;
                end
            end
            default: begin
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        if (result_ok) begin
                            hi_d = result[DW-1:WIDTH];
                            lo_d = result[WIDTH-1:0];
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == RUN);
    assign rd   = hl_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Bench for mdu_hilo: a 32-bit/5/10 instance and a 16-bit/1-cycle-multiply instance,
// each checked every cycle against a latency-and-arithmetic model of HI/LO.
module tb_mdu_hilo;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start_x, w_x, w_sel_x, hl_x, flush_x, busy_x;
    logic [2:0]  op_x;
    logic [31:0] a_x, b_x, wd_x, rd_x;
    logic        start_y, w_y, w_sel_y, hl_y, flush_y, busy_y;
    logic [2:0]  op_y;
    logic [15:0] a_y, b_y, wd_y, rd_y;

    mdu_hilo #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut_x (
        .clk(clk), .reset(reset), .start(start_x), .op(op_x), .a(a_x), .b(b_x),
        .w(w_x), .w_sel(w_sel_x), .wd(wd_x), .hl_sel(hl_x), .flush(flush_x),
        .rd(rd_x), .busy(busy_x)
    );

    mdu_hilo #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(10)) dut_y (
        .clk(clk), .reset(reset), .start(start_y), .op(op_y), .a(a_y), .b(b_y),
        .w(w_y), .w_sel(w_sel_y), .wd(wd_y), .hl_sel(hl_y), .flush(flush_y),
        .rd(rd_y), .busy(busy_y)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    // Requests from the stimulus for literal comparisons, handled by the compare process.
    string       req_name;
    logic [63:0] req_act, req_exp;
    int          req_seq = 0;
    int          done_seq = 0;

    // ---------------- behavioural model ----------------
    logic [63:0] mhx = 0, mlx = 0, phx = 0, plx = 0;
    logic [63:0] mhy = 0, mly = 0, phy = 0, ply = 0;
    int          leftx = 0, lefty = 0;
    bit          protox = 0, protoy = 0;

    function automatic longint sx(input logic [63:0] v, input int wdt);
        logic [63:0] m;
        m = (64'd1 << wdt) - 64'd1;
        v = v & m;
        if (v[wdt-1]) return longint'(v) - (longint'(1) <<< wdt);
        return longint'(v);
    endfunction

    function automatic void mcalc(input int wdt, input logic [2:0] o,
                                  input logic [63:0] av, input logic [63:0] bv,
                                  input logic [63:0] hi, input logic [63:0] lo,
                                  output logic [63:0] nhi, output logic [63:0] nlo);
        logic [63:0] m1, m2, acc, p, r;
        longint      sa, sb;
        m1  = (64'd1 << wdt) - 64'd1;
        m2  = (wdt == 32) ? '1 : ((64'd1 << (2 * wdt)) - 64'd1);
        av  = av & m1;
        bv  = bv & m1;
        sa  = sx(av, wdt);
        sb  = sx(bv, wdt);
        acc = (hi << wdt) | lo;
        if (!o[0]) p = 64'(sa * sb);
        else       p = av * bv;
        if (o == 3'b010 || o == 3'b011) begin
            if (bv == 0) begin
                nhi = hi;
                nlo = lo;
                return;
            end
            if (o == 3'b010) r = ((64'(sa % sb) & m1) << wdt) | (64'(sa / sb) & m1);
            else             r = ((av % bv) << wdt) | (av / bv);
        end else if (o[2] && o[1]) r = acc - p;
        else if (o[2])             r = acc + p;
        else                       r = p;
        r   = r & m2;
        nhi = (r >> wdt) & m1;
        nlo = r & m1;
    endfunction

    always @(posedge clk) begin
        protox = 0;
        if (reset) begin
            mhx = 0; mlx = 0; leftx = 0;
        end else if (leftx > 0) begin
            protox = start_x || w_x;
            if (flush_x) leftx = 0;
            else begin
                leftx = leftx - 1;
                if (leftx == 0) begin mhx = phx; mlx = plx; end
            end
        end else if (start_x && !flush_x) begin
            mcalc(32, op_x, 64'(a_x), 64'(b_x), mhx, mlx, phx, plx);
            leftx = (op_x[2:1] == 2'b01) ? 10 : 5;
        end else if (w_x) begin
            if (w_sel_x) mhx = 64'(wd_x);
            else         mlx = 64'(wd_x);
        end
    end

    always @(posedge clk) begin
        protoy = 0;
        if (reset) begin
            mhy = 0; mly = 0; lefty = 0;
        end else if (lefty > 0) begin
            protoy = start_y || w_y;
            if (flush_y) lefty = 0;
            else begin
                lefty = lefty - 1;
                if (lefty == 0) begin mhy = phy; mly = ply; end
            end
        end else if (start_y && !flush_y) begin
            mcalc(16, op_y, 64'(a_y), 64'(b_y), mhy, mly, phy, ply);
            lefty = (op_y[2:1] == 2'b01) ? 10 : 1;
        end else if (w_y) begin
            if (w_sel_y) mhy = 64'(wd_y);
            else         mly = 64'(wd_y);
        end
    end

    // ---------------- compare process ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        hl_x = 1'b0;
        hl_y = 1'b0;
        forever begin
            @(negedge clk);
            if (req_seq != done_seq) begin
                done_seq = req_seq;
                chk(req_name, req_act, req_exp);
            end
            if (protox || protoy) begin
                errors++;
                $display("FAIL protocol: start or w issued while busy at %0t", $time);
            end
            if (chk_en) begin
                chk("busy_x", 64'(busy_x), 64'(leftx > 0));
                chk("busy_y", 64'(busy_y), 64'(lefty > 0));
                hl_x = 1'b0; hl_y = 1'b0;
                #1;
                chk("lo_x", 64'(rd_x), mlx);
                chk("lo_y", 64'(rd_y), mly);
                hl_x = 1'b1; hl_y = 1'b1;
                #1;
                chk("hi_x", 64'(rd_x), mhx);
                chk("hi_y", 64'(rd_y), mhy);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic submit(input string nm, input logic [63:0] act, input logic [63:0] exp);
        req_name = nm;
        req_act  = act;
        req_exp  = exp;
        req_seq++;
        @(negedge clk);
        #3;
    endtask

    task automatic count_busy_x(input int n, input string nm);
        int c;
        c = 0;
        while (busy_x && c < 200) begin c++; tick(); end
        submit({nm, "_busy_cycles"}, 64'(c), 64'(n));
    endtask

    task automatic run_x(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input int n, input string nm);
        start_x = 1'b1; op_x = o; a_x = av; b_x = bv;
        tick();
        start_x = 1'b0; a_x = ~av; b_x = 32'h5A5A_5A5A;
        count_busy_x(n, nm);
    endtask

    task automatic mt_x(input logic sel, input logic [31:0] d);
        w_x = 1'b1; w_sel_x = sel; wd_x = d;
        tick();
        w_x = 1'b0;
    endtask

    task automatic lit_x(input string nm, input logic [31:0] eh, input logic [31:0] el);
        submit(nm, {mhx[31:0], mlx[31:0]}, {eh, el});
    endtask

    task automatic lit_y(input string nm, input logic [15:0] eh, input logic [15:0] el);
        submit(nm, {32'h0, mhy[15:0], mly[15:0]}, {32'h0, eh, el});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        reset = 1'b1;
        start_x = 0; op_x = 0; a_x = 0; b_x = 0; w_x = 0; w_sel_x = 0; wd_x = 0; flush_x = 0;
        start_y = 0; op_y = 0; a_y = 0; b_y = 0; w_y = 0; w_sel_y = 0; wd_y = 0; flush_y = 0;
        tick(); tick();
        reset = 1'b0;
        chk_en = 1;
        submit("reset_busy", 64'(busy_x), 64'd0);
        lit_x("reset_hilo", 32'h0, 32'h0);

        // reset in the 2nd busy cycle of mult 7*6
        start_x = 1'b1; op_x = 3'b000; a_x = 32'd7; b_x = 32'd6;
        tick();
        start_x = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        submit("rst_mid_busy", 64'(busy_x), 64'd0);
        lit_x("rst_mid_hilo", 32'h0, 32'h0);
        repeat (8) tick();

        run_x(3'b000, 32'hFFFF_FFFE, 32'd3, 5, "mult");
        lit_x("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_x(3'b001, 32'hFFFF_FFFE, 32'd3, 5, "multu");
        lit_x("multu", 32'h0000_0002, 32'hFFFF_FFFA);
        run_x(3'b010, 32'hFFFF_FFF9, 32'd2, 10, "div");
        lit_x("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_x(3'b011, 32'h8000_0000, 32'd0, 10, "divu_zero");
        lit_x("divu_zero", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_x(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 10, "div_min");
        lit_x("div_min", 32'h0, 32'h8000_0000);

        mt_x(1'b0, 32'hFFFF_FFFF);
        lit_x("mtlo", 32'h0, 32'hFFFF_FFFF);
        mt_x(1'b1, 32'h0);
        lit_x("mthi", 32'h0, 32'hFFFF_FFFF);
        run_x(3'b101, 32'd1, 32'd1, 5, "maddu");
        lit_x("maddu", 32'h1, 32'h0);
        run_x(3'b110, 32'd1, 32'd2, 5, "msub");
        lit_x("msub", 32'h0, 32'hFFFF_FFFE);

        // flush on the 3rd busy cycle
        start_x = 1'b1; op_x = 3'b000; a_x = 32'd3; b_x = 32'd3;
        tick();
        start_x = 1'b0;
        tick(); tick();
        flush_x = 1'b1;
        tick();
        flush_x = 1'b0;
        submit("flush_busy", 64'(busy_x), 64'd0);
        lit_x("flush_hilo", 32'h0, 32'hFFFF_FFFE);
        repeat (6) tick();

        // start and w together: start wins
        start_x = 1'b1; op_x = 3'b000; a_x = 32'd3; b_x = 32'd3;
        w_x = 1'b1; w_sel_x = 1'b1; wd_x = 32'hDEAD_BEEF;
        tick();
        start_x = 1'b0; w_x = 1'b0;
        count_busy_x(5, "start_w");
        lit_x("start_w", 32'h0, 32'h9);

        run_x(3'b100, 32'hFFFF_FFFF, 32'd1, 5, "madd");
        lit_x("madd", 32'h0, 32'h8);

        // flush in IDLE blocks a coincident start
        start_x = 1'b1; flush_x = 1'b1; op_x = 3'b000; a_x = 32'd2; b_x = 32'd2;
        tick();
        start_x = 1'b0; flush_x = 1'b0;
        submit("idle_flush_busy", 64'(busy_x), 64'd0);
        lit_x("idle_flush_hilo", 32'h0, 32'h8);

        // narrow instance, single-cycle multiply
        start_y = 1'b1; op_y = 3'b000; a_y = 16'h8000; b_y = 16'h8000;
        tick();
        start_y = 1'b0;
        c = 0;
        while (busy_y && c < 50) begin c++; tick(); end
        submit("mult16_busy_cycles", 64'(c), 64'd1);
        lit_y("mult16", 16'h4000, 16'h0000);
        w_y = 1'b1; w_sel_y = 1'b0; wd_y = 16'h1111;
        tick();
        w_y = 1'b0;
        lit_y("mtlo16", 16'h4000, 16'h1111);
        start_y = 1'b1; op_y = 3'b000; a_y = 16'd2; b_y = 16'd3;
        w_y = 1'b1; w_sel_y = 1'b1; wd_y = 16'hAAAA;
        tick();
        start_y = 1'b0; w_y = 1'b0;
        c = 0;
        while (busy_y && c < 50) begin c++; tick(); end
        submit("start_w16_busy_cycles", 64'(c), 64'd1);
        lit_y("start_w16", 16'h0000, 16'h0006);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
